lsu_mem_if: RTL and testbench
=============================

Name: lsu_mem_if

Overview:
- Load/store unit sitting directly upstream of `Data_Memory`, between the execute stage and the data-memory port.
- Converts byte addresses and RV32I `funct3` sizes into word-indexed `Mem_*` accesses.
- Performs sub-word stores as a 2-cycle read-modify-write, and sign/zero-extends load data.
- Registers the load result for writeback, and flags misaligned and illegal accesses.

Parameters:
- DEPTH_WORDS, 32, number of 32-bit words in data memory; must be a power of 2.
- IDX_W, 5, word-index width, equal to log2(DEPTH_WORDS).

Ports:
- clk_i  input  1  system clock; all state on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- lsu_req_i  input  1  access request from execute; held by upstream while lsu_busy_o=1.
- lsu_we_i  input  1  1=store, 0=load.
- lsu_funct3_i  input  3  RV32I size/sign code (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101).
- lsu_addr_i  input  32  byte address.
- lsu_wdata_i  input  32  store data, right-aligned.
- lsu_busy_o  output  1  stall: a new request is not accepted this cycle.
- lsu_rvalid_o  output  1  1-cycle pulse: lsu_rdata_o holds a completed load.
- lsu_rdata_o  output  32  extended load data, registered.
- lsu_misaligned_o  output  1  1-cycle pulse: request rejected as misaligned.
- lsu_fault_o  output  1  1-cycle pulse: request rejected (illegal funct3 / out of range).
- Mem_read  output  1  to `Data_Memory`, combinational.
- Mem_write  output  1  to `Data_Memory`; memory writes at the next rising edge.
- Mem_addr  output  32  word index = byte address >> 2, zero-extended.
- Mem_write_data  output  32  full word to write.
- Mem_out  input  32  combinational read data from `Data_Memory`.

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE; merge buffer and latched address/funct3 cleared.
  - lsu_rdata_o=0; lsu_rvalid_o, lsu_misaligned_o, lsu_fault_o, lsu_busy_o all 0.
  - Mem_read=Mem_write=0 while rst_ni=0.
- FSM states are IDLE and RMW_WRITE. lsu_busy_o = (state==RMW_WRITE), so it is registered.
- Requests are accepted only in IDLE with lsu_req_i=1. A request presented in RMW_WRITE is ignored and must be held.
- Misaligned rule:
  - Halfword access with addr[0]=1 is misaligned.
  - Word access with addr[1:0]!=0 is misaligned.
  - On a misaligned request: no Mem_read/Mem_write, lsu_misaligned_o pulses next cycle, no lsu_rvalid_o.
- Load (IDLE, accepted, legal):
  - Same cycle: Mem_read=1, Mem_addr = addr[IDX_W+1:2].
  - At the edge, extract the byte (addr[1:0]) or half (addr[1]) from Mem_out.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
  - Result is registered into lsu_rdata_o with lsu_rvalid_o=1 for exactly 1 cycle. Latency 1.
  - lsu_rdata_o holds its value until the next load completes.
- SW: same cycle Mem_write=1 and Mem_write_data=lsu_wdata_i. Completes in 1 cycle; no busy.
- SB/SH:
  - Accept cycle: Mem_read=1. At the edge, the merge buffer takes Mem_out with the selected byte/half lane replaced by wdata[7:0] / wdata[15:0]. Latch Mem_addr. Go to RMW_WRITE.
  - RMW_WRITE: Mem_write=1, Mem_write_data=merge buffer. Return to IDLE at the edge.
- Total sub-word store occupancy is 2 cycles. A load accepted in the cycle after RMW_WRITE observes the merged word.
- Loads, SW and rejected requests never raise lsu_busy_o.
- Reset during RMW_WRITE: the write is not issued (Mem_write forced 0 asynchronously) and memory is unchanged.
- Back-to-back legal loads/SW are accepted every cycle.

Optional Feature:
- Macro LSU_FAULT_EN.
- Defined:
  - funct3 011/110/111, or a store with funct3[2]=1, is illegal.
  - Byte address >= DEPTH_WORDS*4 is out of range.
  - Either condition: no memory access and lsu_fault_o pulses next cycle.
  - If both misaligned and fault apply, lsu_fault_o takes priority.
- Undefined:
  - lsu_fault_o tied 0.
  - Word index wraps modulo DEPTH_WORDS.
  - Illegal funct3 is treated as LW/SW.

Test Plan:
1. Memory word 12 = 0x00000008; LW addr 0x30 -> next cycle lsu_rvalid_o=1, lsu_rdata_o=0x00000008, lsu_busy_o stays 0.
2. SB addr 0x31 wdata 0x000000AB -> lsu_busy_o=1 for 1 cycle with Mem_write=1, Mem_addr=12, Mem_write_data=0x0000AB08. Then LB 0x31 -> 0xFFFFFFAB, and LBU 0x31 -> 0x000000AB.
3. SH addr 0x32 wdata 0x00001234 after test 2 -> word 12 = 0x1234AB08. Then LH 0x32 -> 0x00001234.
4. LH addr 0x31 -> lsu_misaligned_o pulses 1 cycle, Mem_read/Mem_write never asserted, no lsu_rvalid_o.
5. LSU_FAULT_EN defined: LW addr 0x80 -> lsu_fault_o pulse, no memory access. Undefined: LW addr 0x80 reads word 0 (wrap).
6. SB addr 0x30 wdata 0xFF with rst_ni pulled low during RMW_WRITE -> Mem_write=0, word 12 unchanged, all outputs 0, state IDLE after release.

Source files
------------

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store unit in front of Data_Memory.
// Converts byte addresses and RV32I funct3 sizes into word-indexed Mem_* accesses.
// Sub-word stores run as a 2-cycle read-modify-write; loads are extended and registered.
// Optional macro LSU_FAULT_EN: flag illegal funct3 and out-of-range addresses on lsu_fault_o.
module lsu_mem_if #(
    parameter int DEPTH_WORDS = 32,
    parameter int IDX_W       = 5
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_funct3_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_busy_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_misaligned_o,
    output logic        lsu_fault_o,
    output logic        Mem_read,
    output logic        Mem_write,
    output logic [31:0] Mem_addr,
    output logic [31:0] Mem_write_data,
    input  logic [31:0] Mem_out
);

    localparam logic S_IDLE      = 1'b0;
    localparam logic S_RMW_WRITE = 1'b1;

    logic             r_state;
    logic [31:0]      r_merge;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_rdata;
    logic             r_rvalid;
    logic             r_misaligned;
    logic             r_fault;

    logic             w_sz_byte;
    logic             w_sz_half;
    logic             w_sz_word;
    logic             w_illegal;
    logic             w_misaligned;
    logic             w_fault;
    logic             w_accept;
    logic             w_legal;
    logic             w_load;
    logic             w_sw;
    logic             w_subst;
    logic [IDX_W-1:0] w_idx;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_ext;
    logic [31:0]      w_merged;

    assign w_idx = lsu_addr_i[IDX_W+1:2];

    // Decode access size; unknown codes (and stores with funct3[2]=1) fall back to word size.
    always_comb begin
        w_sz_byte = (lsu_funct3_i == 3'b000) || (lsu_funct3_i == 3'b100 && !lsu_we_i);
        w_sz_half = (lsu_funct3_i == 3'b001) || (lsu_funct3_i == 3'b101 && !lsu_we_i);
        w_sz_word = !w_sz_byte && !w_sz_half;
        w_illegal = (lsu_funct3_i == 3'b011) || (lsu_funct3_i == 3'b110) ||
                    (lsu_funct3_i == 3'b111) || (lsu_we_i && lsu_funct3_i[2]);
    end

    // Classify the request: misaligned, faulting (when enabled), or legal.
    always_comb begin
        w_misaligned = (w_sz_half && lsu_addr_i[0]) || (w_sz_word && (lsu_addr_i[1:0] != 2'b00));
`ifdef LSU_FAULT_EN
        w_fault = w_illegal || (lsu_addr_i >= 32'(DEPTH_WORDS * 4));
`else
        w_fault = 1'b0;
`endif
        w_accept = rst_ni && (r_state == S_IDLE) && lsu_req_i;
        w_legal  = w_accept && !w_misaligned && !w_fault;
        w_load   = w_legal && !lsu_we_i;
        w_sw     = w_legal && lsu_we_i && w_sz_word;
        w_subst  = w_legal && lsu_we_i && !w_sz_word;
    end

    // Select and extend load lanes, and build the merged word for sub-word stores.
    always_comb begin
        case (lsu_addr_i[1:0])
            2'd0:    w_byte = Mem_out[7:0];
            2'd1:    w_byte = Mem_out[15:8];
            2'd2:    w_byte = Mem_out[23:16];
            default: w_byte = Mem_out[31:24];
        endcase
        w_half = lsu_addr_i[1] ? Mem_out[31:16] : Mem_out[15:0];
        if (w_sz_byte)
            w_ext = lsu_funct3_i[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
        else if (w_sz_half)
            w_ext = lsu_funct3_i[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
        else
            w_ext = Mem_out;
        w_merged = Mem_out;
        if (w_sz_byte) begin
            case (lsu_addr_i[1:0])
                2'd0:    w_merged[7:0]   = lsu_wdata_i[7:0];
                2'd1:    w_merged[15:8]  = lsu_wdata_i[7:0];
                2'd2:    w_merged[23:16] = lsu_wdata_i[7:0];
                default: w_merged[31:24] = lsu_wdata_i[7:0];
            endcase
        end else if (lsu_addr_i[1]) begin
            w_merged[31:16] = lsu_wdata_i[15:0];
        end else begin
            w_merged[15:0] = lsu_wdata_i[15:0];
        end
    end

    // Drive the memory port; strobes are gated by rst_ni so reset kills a pending write.
    always_comb begin
        Mem_read  = w_load || w_subst;
        Mem_write = rst_ni && ((r_state == S_RMW_WRITE) || w_sw);
        if (r_state == S_RMW_WRITE) begin
            Mem_addr       = {{(32-IDX_W){1'b0}}, r_idx};
            Mem_write_data = r_merge;
        end else begin
            Mem_addr       = {{(32-IDX_W){1'b0}}, w_idx};
            Mem_write_data = lsu_wdata_i;
        end
    end

    // FSM, merge buffer, load result register and status pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_merge      <= '0;
            r_idx        <= '0;
            r_rdata      <= '0;
            r_rvalid     <= 1'b0;
            r_misaligned <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_rvalid     <= w_load;
            r_misaligned <= w_accept && w_misaligned && !w_fault;
            r_fault      <= w_accept && w_fault;
            if (w_load)
                r_rdata <= w_ext;
            case (r_state)
                S_IDLE: begin
                    if (w_subst) begin
                        r_merge <= w_merged;
                        r_idx   <= w_idx;
                        r_state <= S_RMW_WRITE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign lsu_busy_o       = (r_state == S_RMW_WRITE);
    assign lsu_rvalid_o     = r_rvalid;
    assign lsu_rdata_o      = r_rdata;
    assign lsu_misaligned_o = r_misaligned;
    assign lsu_fault_o      = r_fault;

endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: directed bench for lsu_mem_if with a behavioural Data_Memory.
module tb_lsu_mem_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, rvalid, misal, fault;
    logic [31:0] rdata;
    logic        mrd, mwr;
    logic [31:0] maddr, mwdata, mout;

    logic [31:0] mem [0:31];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_mem_if #(.DEPTH_WORDS(32), .IDX_W(5)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .lsu_req_i(req), .lsu_we_i(we), .lsu_funct3_i(f3),
        .lsu_addr_i(addr), .lsu_wdata_i(wdata),
        .lsu_busy_o(busy), .lsu_rvalid_o(rvalid), .lsu_rdata_o(rdata),
        .lsu_misaligned_o(misal), .lsu_fault_o(fault),
        .Mem_read(mrd), .Mem_write(mwr), .Mem_addr(maddr),
        .Mem_write_data(mwdata), .Mem_out(mout)
    );

    assign mout = mem[maddr[4:0]];

    always @(posedge clk)
        if (mwr) mem[maddr[4:0]] <= mwdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [2:0] fn, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = w; f3 = fn; addr = a; wdata = d;
        #1;
    endtask

    task automatic drop();
        @(negedge clk);
        req = 1'b0;
        #1;
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[0]  = 32'hDEADBEEF;
        mem[12] = 32'h00000008;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; f3 = 3'b010; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   {31'h0, busy},   0);
        chk("rst_rvalid", {31'h0, rvalid}, 0);
        chk("rst_rdata",  rdata,           0);
        chk("rst_mwr",    {31'h0, mwr},    0);
        chk("rst_mrd",    {31'h0, mrd},    0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: LW 0x30
        issue(1'b0, 3'b010, 32'h30, 0);
        chk("lw_mrd",   {31'h0, mrd}, 1);
        chk("lw_maddr", maddr, 12);
        edge_();
        chk("lw_rvalid", {31'h0, rvalid}, 1);
        chk("lw_rdata",  rdata, 32'h00000008);
        chk("lw_busy",   {31'h0, busy}, 0);
        // back-to-back: LW 0x00 the very next cycle
        @(negedge clk); addr = 32'h0; #1;
        edge_();
        chk("b2b_rvalid", {31'h0, rvalid}, 1);
        chk("b2b_rdata",  rdata, 32'hDEADBEEF);
        drop();
        edge_();
        chk("rvalid_pulse", {31'h0, rvalid}, 0);
        chk("rdata_hold",   rdata, 32'hDEADBEEF);

        // 2: SB 0x31 0xAB, request held through RMW_WRITE
        issue(1'b1, 3'b000, 32'h31, 32'h000000AB);
        chk("sb_mrd",  {31'h0, mrd}, 1);
        chk("sb_mwr0", {31'h0, mwr}, 0);
        edge_();
        chk("sb_busy",   {31'h0, busy}, 1);
        chk("sb_mwr",    {31'h0, mwr},  1);
        chk("sb_maddr",  maddr, 12);
        chk("sb_mwdata", mwdata, 32'h0000AB08);
        drop();
        edge_();
        chk("sb_busy_end", {31'h0, busy}, 0);
        chk("sb_mem",      mem[12], 32'h0000AB08);
        issue(1'b0, 3'b000, 32'h31, 0);
        edge_();
        chk("lb_rdata", rdata, 32'hFFFFFFAB);
        @(negedge clk); f3 = 3'b100; #1;
        edge_();
        chk("lbu_rdata", rdata, 32'h000000AB);
        drop();

        // 3: SH 0x32 0x1234
        issue(1'b1, 3'b001, 32'h32, 32'h00001234);
        edge_();
        chk("sh_mwdata", mwdata, 32'h1234AB08);
        drop();
        edge_();
        chk("sh_mem", mem[12], 32'h1234AB08);
        issue(1'b0, 3'b001, 32'h32, 0);
        edge_();
        chk("lh_hi", rdata, 32'h00001234);
        @(negedge clk); addr = 32'h30; #1;
        edge_();
        chk("lh_lo_sext", rdata, 32'hFFFFAB08);
        @(negedge clk); f3 = 3'b101; #1;
        edge_();
        chk("lhu_lo", rdata, 32'h0000AB08);
        drop();

        // SW 0x04 then load it back
        issue(1'b1, 3'b010, 32'h04, 32'h55AA55AA);
        chk("sw_mwr",    {31'h0, mwr}, 1);
        chk("sw_mwdata", mwdata, 32'h55AA55AA);
        edge_();
        chk("sw_busy", {31'h0, busy}, 0);
        chk("sw_mem",  mem[1], 32'h55AA55AA);
        drop();

        // 4: misaligned LH 0x31 and LW 0x32
        issue(1'b0, 3'b001, 32'h31, 0);
        chk("mis_mrd", {31'h0, mrd}, 0);
        chk("mis_mwr", {31'h0, mwr}, 0);
        edge_();
        chk("mis_pulse",  {31'h0, misal},  1);
        chk("mis_rvalid", {31'h0, rvalid}, 0);
        drop();
        edge_();
        chk("mis_end", {31'h0, misal}, 0);
        issue(1'b0, 3'b010, 32'h32, 0);
        chk("mis_w_mrd", {31'h0, mrd}, 0);
        edge_();
        chk("mis_w_pulse", {31'h0, misal}, 1);
        drop();

        // 5: LW 0x80
        issue(1'b0, 3'b010, 32'h80, 0);
`ifdef LSU_FAULT_EN
        chk("oor_mrd", {31'h0, mrd}, 0);
        edge_();
        chk("oor_fault",  {31'h0, fault},  1);
        chk("oor_rvalid", {31'h0, rvalid}, 0);
`else
        chk("wrap_maddr", maddr[4:0], 0);
        edge_();
        chk("wrap_rdata", rdata, 32'hDEADBEEF);
        chk("wrap_fault", {31'h0, fault}, 0);
`endif
        drop();

        // 6: SB 0x30 0xFF, reset during RMW_WRITE
        issue(1'b1, 3'b000, 32'h30, 32'h000000FF);
        edge_();
        chk("rmw_busy", {31'h0, busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("rstrmw_mwr",   {31'h0, mwr},  0);
        chk("rstrmw_busy",  {31'h0, busy}, 0);
        chk("rstrmw_rdata", rdata, 0);
        req = 1'b0;
        edge_();
        chk("rstrmw_mem", mem[12], 32'h1234AB08);
        @(negedge clk);
        rst_n = 1'b1;
        edge_();
        chk("post_busy",  {31'h0, busy},  0);
        chk("post_mwr",   {31'h0, mwr},   0);
        chk("post_misal", {31'h0, misal}, 0);
        chk("post_mem",   mem[12], 32'h1234AB08);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
